hart_mem_scheduler: RTL and testbench
=====================================

Name: hart_mem_scheduler

Overview:
- Time-slice scheduler for the shared MMU/memory port of a multi-hart RISC-V cluster.
- Grants the port to exactly one hart at a time, rotating round-robin among requesting harts.
- Hand-over happens only at a hart-reported safe point and after the memory port drains.
- Sits between the per-hart cores and the shared MMU/DRAM path. Replaces ad-hoc rotate-on-every-retire selection with a quantum-based, drain-aware hand-over.

Parameters:
- N_HARTS, 2, number of harts sharing the port (≥1).
- QUANTUM, 1024, cycles a hart may own the port before a rotation is considered (≥1).
- SW, (N_HARTS>1)?$clog2(N_HARTS):1, width of the hart index.
- QW, $clog2(QUANTUM+1), width of the quantum counter.

Ports:
- CLK  in  1  clock.
- RST_X  in  1  asynchronous active-low reset.
- w_req  in  N_HARTS  hart g wants the port (not halted/not WFI).
- w_safe  in  N_HARTS  hart g is at a switchable point: pipeline idle, no pending exception, no CSR flush, instruction retired this cycle.
- w_mem_idle  in  1  shared memory/MMU path has no outstanding transaction (page walk and DRAM both idle).
- w_mc_hold  in  1  memory controller in non-CPU mode, or entering it next cycle; blocks hand-over.
- w_mmu_fault  in  1  MMU reports a page fault for the current owner; blocks hand-over.
- w_busy_in  in  1  busy from the shared memory path.
- r_sel  out  SW  index of current/last owner.
- r_grant  out  N_HARTS  one-hot grant; all-zero when no owner.
- w_core_busy  out  N_HARTS  per-hart stall: r_grant[g] ? w_busy_in : 1.
- r_switch  out  1  one-cycle pulse on each new grant.
- r_qleft  out  QW  remaining quantum of the owner.
- r_state  out  2  0=IDLE, 1=OWN, 2=DRAIN.

Behaviour:
- Reset (asynchronous): r_state=IDLE, r_sel=0, r_grant=0, r_switch=0, r_qleft=0. w_core_busy is therefore all-ones. Reset mid-transaction abandons the owner immediately, with no drain.
- next_hart: first index after r_sel, in modulo-N_HARTS order, with w_req=1.
  - If no other hart requests, next_hart is r_sel itself when w_req[r_sel]=1.
  - Otherwise none exists.
- IDLE:
  - If any w_req: r_sel←next_hart (r_sel itself is included last), r_grant←onehot, r_qleft←QUANTUM, r_switch←1, go to OWN. Grant is visible the cycle after the request is sampled.
  - Otherwise stay in IDLE.
- OWN:
  - r_qleft decrements by 1 per cycle and saturates at 0.
  - want_switch = !w_req[r_sel] OR (r_qleft==0 AND some other hart requests).
  - Hand-over when want_switch AND w_safe[r_sel] AND !w_mc_hold AND !w_mmu_fault: r_grant←0, go to DRAIN.
  - If w_req[r_sel]=0, hand-over does not require w_safe[r_sel].
  - If r_qleft==0 and no other hart requests: reload r_qleft←QUANTUM, stay in OWN, no r_switch.
- DRAIN:
  - r_grant=0, so all harts see busy=1.
  - Wait for w_mem_idle=1 AND !w_mc_hold.
  - Then, if next_hart exists: r_sel←next_hart, r_grant←onehot, r_qleft←QUANTUM, r_switch←1, go to OWN.
  - Otherwise go to IDLE; r_sel holds.
  - Minimum hand-over gap is 1 cycle of all-zero grant.
- r_switch is high for exactly the first cycle of each new OWN tenure, including re-grant of the same hart after DRAIN.
- Simultaneous events:
  - w_mc_hold and w_mmu_fault have priority over quantum expiry. The switch is deferred and r_qleft stays 0.
  - A request drop and quantum expiry in the same cycle are treated as one hand-over.
- Invariant: at most one r_grant bit is set. r_grant is nonzero only in OWN.
- N_HARTS=1: rotation always selects hart 0. DRAIN/IDLE are entered only when w_req[0] drops.

Test Plan:
- Reset then w_req=2'b01 → r_grant=01 and r_switch=1 one cycle later; r_qleft=1024, then decrements.
- QUANTUM=8, w_req=2'b11, w_safe=11, w_mem_idle=1 → grant 01 for 9 OWN cycles, then 1 DRAIN cycle with grant 00, then grant 10 with r_switch pulse; rotation repeats indefinitely.
- Quantum expires with w_safe[0]=0 for 5 cycles → grant stays 01, r_qleft=0; hand-over occurs on the cycle w_safe[0] rises.
- Quantum expires with w_mem_idle=0 for 4 DRAIN cycles → r_grant=00 and w_core_busy=11 throughout; grant 10 appears the cycle after w_mem_idle=1.
- Owner's w_req drops with no other requester → DRAIN then IDLE, r_sel unchanged. Hart 1 requests later → grant 10.
- w_mmu_fault=1 or w_mc_hold=1 during expiry → no switch. Assert RST_X low mid-DRAIN → all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hart_mem_scheduler.sv
// Round-robin, quantum-based owner scheduler for the shared MMU/memory port.
// The port changes hands only at a safe point of the owner and after the memory path drains.
module hart_mem_scheduler #(
  parameter int N_HARTS = 2,
  parameter int QUANTUM = 1024,
  parameter int SW      = (N_HARTS > 1) ? $clog2(N_HARTS) : 1,
  parameter int QW      = $clog2(QUANTUM + 1)
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [N_HARTS-1:0] w_req,
  input  logic [N_HARTS-1:0] w_safe,
  input  logic               w_mem_idle,
  input  logic               w_mc_hold,
  input  logic               w_mmu_fault,
  input  logic               w_busy_in,
  output logic [SW-1:0]      r_sel,
  output logic [N_HARTS-1:0] r_grant,
  output logic [N_HARTS-1:0] w_core_busy,
  output logic               r_switch,
  output logic [QW-1:0]      r_qleft,
  output logic [1:0]         r_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [QW-1:0] QFULL = QW'(QUANTUM);

  state_e               state, state_nx;
  logic [SW-1:0]        sel_nx;
  logic [N_HARTS-1:0]   grant_nx;
  logic                 switch_nx;
  logic [QW-1:0]        qleft_nx;

  logic [SW-1:0]        next_hart;
  logic                 next_ok;
  logic                 own_req;
  logic                 own_safe;
  logic                 other_req;
  logic                 want_switch;

  // Scan from the farthest candidate back to the nearest so the nearest
  // requester after r_sel wins; r_sel itself is the farthest (i == N_HARTS).
  always_comb begin
    int          idx;
    logic [SW-1:0] idx_sw;
    next_hart = r_sel;
    next_ok   = 1'b0;
    idx       = 0;
    idx_sw    = '0;
    for (int i = N_HARTS; i >= 1; i--) begin
      idx    = (int'(r_sel) + i) % N_HARTS;
      idx_sw = SW'(idx);
      if (w_req[idx_sw]) begin
        next_hart = idx_sw;
        next_ok   = 1'b1;
      end
    end
  end

  assign own_req     = w_req[r_sel];
  assign own_safe    = w_safe[r_sel];
  assign other_req   = |(w_req & ~(N_HARTS'(1) << r_sel));
  assign want_switch = !own_req || ((r_qleft == '0) && other_req);

  always_comb begin
    state_nx  = state;
    sel_nx    = r_sel;
    grant_nx  = r_grant;
    switch_nx = 1'b0;
    qleft_nx  = r_qleft;
    case (state)
      IDLE: begin
        if (next_ok) begin
          state_nx  = OWN;
          sel_nx    = next_hart;
          grant_nx  = N_HARTS'(1) << next_hart;
          qleft_nx  = QFULL;
          switch_nx = 1'b1;
        end
      end
      OWN: begin
        // A dropped request needs no safe point; hold and fault defer any hand-over.
        if (want_switch && (own_safe || !own_req) && !w_mc_hold && !w_mmu_fault) begin
          state_nx = DRAIN;
          grant_nx = '0;
        end else if ((r_qleft == '0) && own_req && !other_req) begin
          qleft_nx = QFULL;
        end else if (r_qleft != '0) begin
          qleft_nx = r_qleft - QW'(1);
        end
      end
      DRAIN: begin
        if (w_mem_idle && !w_mc_hold) begin
          if (next_ok) begin
            state_nx  = OWN;
            sel_nx    = next_hart;
            grant_nx  = N_HARTS'(1) << next_hart;
            qleft_nx  = QFULL;
            switch_nx = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state    <= IDLE;
      r_sel    <= '0;
      r_grant  <= '0;
      r_switch <= 1'b0;
      r_qleft  <= '0;
    end else begin
      state    <= state_nx;
      r_sel    <= sel_nx;
      r_grant  <= grant_nx;
      r_switch <= switch_nx;
      r_qleft  <= qleft_nx;
    end
  end

  assign w_core_busy = ~r_grant | (r_grant & {N_HARTS{w_busy_in}});
  assign r_state     = state;

endmodule

// File: tb/tb_hart_mem_scheduler.sv
// Directed bench for hart_mem_scheduler (2 harts, quantum 8): rows push expected
// outputs into a scoreboard queue, a monitor pops and compares each cycle.
module tb_hart_mem_scheduler;

  localparam int N_HARTS = 2;
  localparam int QUANTUM = 8;
  localparam int SW      = 1;
  localparam int QW      = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic               CLK;
  logic               RST_X;
  logic [N_HARTS-1:0] w_req;
  logic [N_HARTS-1:0] w_safe;
  logic               w_mem_idle;
  logic               w_mc_hold;
  logic               w_mmu_fault;
  logic               w_busy_in;
  logic [SW-1:0]      r_sel;
  logic [N_HARTS-1:0] r_grant;
  logic [N_HARTS-1:0] w_core_busy;
  logic               r_switch;
  logic [QW-1:0]      r_qleft;
  logic [1:0]         r_state;

  hart_mem_scheduler #(
    .N_HARTS(N_HARTS),
    .QUANTUM(QUANTUM)
  ) dut (
    .CLK        (CLK),
    .RST_X      (RST_X),
    .w_req      (w_req),
    .w_safe     (w_safe),
    .w_mem_idle (w_mem_idle),
    .w_mc_hold  (w_mc_hold),
    .w_mmu_fault(w_mmu_fault),
    .w_busy_in  (w_busy_in),
    .r_sel      (r_sel),
    .r_grant    (r_grant),
    .w_core_busy(w_core_busy),
    .r_switch   (r_switch),
    .r_qleft    (r_qleft),
    .r_state    (r_state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         row;
    logic [1:0] st;
    logic [1:0] g;
    logic       s;
    logic       sw;
    int         q;
    logic [1:0] bz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   row_id   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs are applied this cycle; the expected outputs describe the state
  // already present in this cycle (the inputs take effect in the next row).
  task automatic cyc(input logic [1:0] req, input logic [1:0] safe, input logic idle,
                     input logic hold, input logic fault, input logic bsy,
                     input logic [1:0] st, input logic [1:0] g, input logic s,
                     input logic sw, input int q);
    exp_t e;
    @(posedge CLK);
    #1;
    w_req       = req;
    w_safe      = safe;
    w_mem_idle  = idle;
    w_mc_hold   = hold;
    w_mmu_fault = fault;
    w_busy_in   = bsy;
    e.row = row_id;
    e.st  = st;
    e.g   = g;
    e.s   = s;
    e.sw  = sw;
    e.q   = q;
    e.bz  = ~g | (g & {2{bsy}});
    sb.push_back(e);
    row_id++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("row%0d state", e.row),  32'(r_state),     32'(e.st));
        check($sformatf("row%0d grant", e.row),  32'(r_grant),     32'(e.g));
        check($sformatf("row%0d sel", e.row),    32'(r_sel),       32'(e.s));
        check($sformatf("row%0d switch", e.row), 32'(r_switch),    32'(e.sw));
        check($sformatf("row%0d busy", e.row),   32'(w_core_busy), 32'(e.bz));
        if (e.q >= 0)
          check($sformatf("row%0d qleft", e.row), 32'(r_qleft), 32'(e.q));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, " state"},  32'(r_state),     32'(S_IDLE));
    check({tag, " grant"},  32'(r_grant),     32'(0));
    check({tag, " sel"},    32'(r_sel),       32'(0));
    check({tag, " switch"}, 32'(r_switch),    32'(0));
    check({tag, " qleft"},  32'(r_qleft),     32'(0));
    check({tag, " busy"},   32'(w_core_busy), 32'(2'b11));
  endtask

  initial begin : stim
    int wait_cnt;
    RST_X       = 1'b0;
    w_req       = '0;
    w_safe      = '0;
    w_mem_idle  = 1'b1;
    w_mc_hold   = 1'b0;
    w_mmu_fault = 1'b0;
    w_busy_in   = 1'b0;
    #3;
    check_reset_values("por");
    repeat (2) @(posedge CLK);
    #1 RST_X = 1'b1;

    // Single requester: grant one cycle later, quantum counts down, reloads at 0.
    cyc(2'b01, 2'b00, 1, 0, 0, 0, S_IDLE, 2'b00, 0, 0, 0);
    cyc(2'b01, 2'b00, 1, 0, 0, 0, S_OWN,  2'b01, 0, 1, 8);
    cyc(2'b01, 2'b00, 1, 0, 0, 1, S_OWN,  2'b01, 0, 0, 7);
    for (int k = 3; k <= 9; k++)
      cyc(2'b01, 2'b00, 1, 0, 0, 0, S_OWN, 2'b01, 0, 0, 9 - k);
    cyc(2'b01, 2'b00, 1, 0, 0, 0, S_OWN, 2'b01, 0, 0, 8);

    // Both request: expiry, one DRAIN cycle, rotate to hart 1.
    cyc(2'b11, 2'b11, 1, 0, 0, 0, S_OWN, 2'b01, 0, 0, 7);
    for (int k = 12; k <= 18; k++)
      cyc(2'b11, 2'b11, 1, 0, 0, 0, S_OWN, 2'b01, 0, 0, 18 - k);
    cyc(2'b11, 2'b01, 1, 0, 0, 0, S_DRAIN, 2'b00, 0, 0, -1);
    cyc(2'b11, 2'b01, 1, 0, 0, 0, S_OWN,   2'b10, 1, 1, 8);

    // Owner not safe at expiry: grant holds with qleft saturated at 0.
    for (int k = 21; k <= 28; k++)
      cyc(2'b11, 2'b01, 1, 0, 0, 0, S_OWN, 2'b10, 1, 0, 28 - k);
    for (int k = 29; k <= 32; k++)
      cyc(2'b11, 2'b01, 1, 0, 0, 0, S_OWN, 2'b10, 1, 0, 0);
    cyc(2'b11, 2'b11, 1, 0, 0, 0, S_OWN, 2'b10, 1, 0, 0);

    // Memory path busy: DRAIN stretches, all harts stalled.
    for (int k = 34; k <= 37; k++)
      cyc(2'b11, 2'b11, 0, 0, 0, 0, S_DRAIN, 2'b00, 1, 0, -1);
    cyc(2'b11, 2'b11, 1, 0, 0, 0, S_DRAIN, 2'b00, 1, 0, -1);
    cyc(2'b11, 2'b11, 1, 0, 0, 0, S_OWN,   2'b01, 0, 1, 8);

    // Hold and fault defer the expiry hand-over; hold also stalls DRAIN.
    for (int k = 40; k <= 45; k++)
      cyc(2'b11, 2'b11, 1, 0, 0, 0, S_OWN, 2'b01, 0, 0, 47 - k);
    cyc(2'b11, 2'b11, 1, 1, 0, 0, S_OWN, 2'b01, 0, 0, 1);
    cyc(2'b11, 2'b11, 1, 1, 0, 0, S_OWN, 2'b01, 0, 0, 0);
    cyc(2'b11, 2'b11, 1, 0, 1, 0, S_OWN, 2'b01, 0, 0, 0);
    cyc(2'b11, 2'b11, 1, 0, 1, 0, S_OWN, 2'b01, 0, 0, 0);
    cyc(2'b11, 2'b11, 1, 0, 0, 0, S_OWN, 2'b01, 0, 0, 0);
    cyc(2'b11, 2'b11, 1, 1, 0, 0, S_DRAIN, 2'b00, 0, 0, -1);
    cyc(2'b11, 2'b11, 1, 0, 0, 0, S_DRAIN, 2'b00, 0, 0, -1);

    // Owner drops its request, nobody else wants the port: DRAIN then IDLE.
    cyc(2'b10, 2'b00, 1, 0, 0, 0, S_OWN,   2'b10, 1, 1, 8);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, S_OWN,   2'b10, 1, 0, 7);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, S_DRAIN, 2'b00, 1, 0, -1);
    cyc(2'b00, 2'b00, 1, 0, 0, 0, S_IDLE,  2'b00, 1, 0, -1);
    cyc(2'b10, 2'b00, 1, 0, 0, 0, S_IDLE,  2'b00, 1, 0, -1);
    cyc(2'b10, 2'b00, 1, 0, 0, 0, S_OWN,   2'b10, 1, 1, 8);
    cyc(2'b00, 2'b00, 0, 0, 0, 0, S_OWN,   2'b10, 1, 0, 7);
    cyc(2'b00, 2'b00, 0, 0, 0, 0, S_DRAIN, 2'b00, 1, 0, -1);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 10) begin
      @(posedge CLK);
      wait_cnt++;
    end
    check("scoreboard_empty", 32'(sb.size()), 32'(0));

    // Asynchronous reset in the middle of DRAIN, away from any clock edge.
    @(posedge CLK);
    #1;
    check("pre_reset state", 32'(r_state), 32'(S_DRAIN));
    check("pre_reset sel",   32'(r_sel),   32'(1));
    RST_X = 1'b0;
    #1;
    check_reset_values("async_rst");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values("held_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
